// File: rtl/sramlike_mem_responder.sv
// Single-outstanding SRAM-like memory responder: byte-masked writes, full-word reads, fixed latency.
// Optional macro SRAMLIKE_RESP_RANDOM_DELAY_EN adds LFSR-driven accept and response stalls.
module sramlike_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic        busy
);

  localparam int unsigned AW = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_q;
  logic [4:0]            cnt_q;
  logic [AW-1:0]         addr_q;
  logic                  wr_q;
  logic [1:0]            size_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic                  data_ok_q;
  logic                  busy_q;
  logic [31:0]           mem [2**DEPTH_LOG2];

  logic                  hs;
  logic                  accept;
  logic [4:0]            cnt_load;
  logic [DEPTH_LOG2-1:0] idx_in;
  logic [DEPTH_LOG2-1:0] idx_lat;
  logic [3:0]            mask_in;
  logic [3:0]            mask_lat;
  logic                  unused_addr_hi;

  // Byte-lane write enables; reads and misaligned writes touch no lanes.
  function automatic logic [3:0] lane_mask(input logic w, input logic [1:0] sz,
                                           input logic [1:0] lo);
    logic [3:0] m;
    m = '0;
    if (w) begin
      unique case (sz)
        2'd0:    m = 4'b0001 << lo;
        2'd1:    if (!lo[0]) m = lo[1] ? 4'b1100 : 4'b0011;
        default: if (lo == 2'b00) m = '1;
      endcase
    end
    return m;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int unsigned b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

`ifdef SRAMLIKE_RESP_RANDOM_DELAY_EN
  logic [15:0] lfsr_q;
  logic [1:0]  stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign accept   = (stall_q == 2'd0);
  assign cnt_load = 5'(LATENCY - 1) + {3'b000, lfsr_q[3:2]};
`else
  assign accept   = 1'b1;
  assign cnt_load = 5'(LATENCY - 1);
`endif

  assign addr_ok        = (state_q == IDLE) && accept && !rst;
  assign hs             = req && addr_ok;
  assign idx_in         = addr[AW-1:2];
  assign idx_lat        = addr_q[AW-1:2];
  assign mask_in        = lane_mask(wr, size, addr[1:0]);
  assign mask_lat       = lane_mask(wr_q, size_q, addr_q[1:0]);
  assign unused_addr_hi = ^addr[31:AW];

  // Memory is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++)
      if (hs && mask_in[b]) mem[idx_in][8*b +: 8] <= wdata[8*b +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      size_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      data_ok_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SRAMLIKE_RESP_RANDOM_DELAY_EN
      stall_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
`ifdef SRAMLIKE_RESP_RANDOM_DELAY_EN
          if (stall_q != 2'd0) stall_q <= stall_q - 2'd1;
`endif
          if (hs) begin
            addr_q  <= addr[AW-1:0];
            wr_q    <= wr;
            size_q  <= size;
            wdata_q <= wdata;
            busy_q  <= 1'b1;
            if (cnt_load == 5'd0) begin
              // Memory commits on this same edge, so merge the incoming write here.
              state_q   <= RESP;
              data_ok_q <= 1'b1;
              rdata_q   <= merge(mem[idx_in], wdata, mask_in);
            end else begin
              state_q <= WAIT;
              cnt_q   <= cnt_load;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            // Write already committed; re-merging the latched lanes is idempotent.
            state_q   <= RESP;
            data_ok_q <= 1'b1;
            rdata_q   <= merge(mem[idx_lat], wdata_q, mask_lat);
          end
        end
        RESP: begin
          state_q   <= IDLE;
          data_ok_q <= 1'b0;
          busy_q    <= 1'b0;
`ifdef SRAMLIKE_RESP_RANDOM_DELAY_EN
          stall_q   <= lfsr_q[1:0];
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata   = rdata_q;
  assign data_ok = data_ok_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_sramlike_mem_responder.sv
// Directed bench for sramlike_mem_responder (default build, DEPTH_LOG2=10, LATENCY=2).
module tb_sramlike_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;
  logic        busy;

  int checks = 0;
  int errors = 0;

  sramlike_mem_responder #(
    .DEPTH_LOG2(10),
    .LATENCY   (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .wr     (wr),
    .size   (size),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .addr_ok(addr_ok),
    .data_ok(data_ok),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One transaction: handshake, then measure cycles to data_ok and check the response.
  task automatic do_txn(input string tag, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
    int n;
    int lat;
    @(negedge clk);
    req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
    n = 0;
    while (!addr_ok && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_aok"}, addr_ok, 1);
    @(negedge clk);
    req = 1'b0; wr = 1'b1; size = 2'd2; addr = 32'hFFFF_FFFC; wdata = 32'h0BAD_0BAD;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_aok_wait"}, addr_ok, 0);
    lat = 1;
    while (!data_ok && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_rdata"}, rdata, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, data_ok, 0);
    chk({tag, "_hold"}, rdata, exp);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    vecs[0]  = '{1'b1, 2'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 2'd2, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 2'd2, 32'h0000_0200, 32'h0000_0000, 32'h0000_0000};
    vecs[3]  = '{1'b1, 2'd0, 32'h0000_0203, 32'hAB00_0000, 32'hAB00_0000};
    vecs[4]  = '{1'b1, 2'd1, 32'h0000_0200, 32'h0000_1234, 32'hAB00_1234};
    vecs[5]  = '{1'b0, 2'd0, 32'h0000_0200, 32'h0000_0000, 32'hAB00_1234};
    vecs[6]  = '{1'b1, 2'd2, 32'h0000_0300, 32'h1122_3344, 32'h1122_3344};
    vecs[7]  = '{1'b1, 2'd2, 32'h0000_0302, 32'hFFFF_FFFF, 32'h1122_3344};
    vecs[8]  = '{1'b0, 2'd2, 32'h0000_0300, 32'h0000_0000, 32'h1122_3344};
    vecs[9]  = '{1'b1, 2'd1, 32'h0000_0301, 32'hFFFF_FFFF, 32'h1122_3344};
    vecs[10] = '{1'b1, 2'd2, 32'h0000_1004, 32'h5A5A_5A5A, 32'h5A5A_5A5A};
    vecs[11] = '{1'b0, 2'd2, 32'h0000_0004, 32'h0000_0000, 32'h5A5A_5A5A};
    vecs[12] = '{1'b1, 2'd0, 32'h0000_0005, 32'h0000_CC00, 32'h5A5A_CC5A};
    vecs[13] = '{1'b0, 2'd3, 32'h0000_1005, 32'h0000_0000, 32'h5A5A_CC5A};
    vecs[14] = '{1'b1, 2'd1, 32'h0000_0102, 32'h1234_0000, 32'h1234_BEEF};
    vecs[15] = '{1'b0, 2'd1, 32'h0000_0103, 32'h0000_0000, 32'h1234_BEEF};

    rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = '0; wdata = '0;
    #12;
    chk("rst_aok", addr_ok, 0);
    chk("rst_dok", data_ok, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_aok", addr_ok, 1);
    chk("rel_busy", busy, 0);

    for (int i = 0; i < 16; i++)
      do_txn($sformatf("v%0d", i), vecs[i].w, vecs[i].sz, vecs[i].a, vecs[i].d, vecs[i].exp);

    // req held high: handshake every 3 cycles, data_ok on the third.
    @(negedge clk);
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0000_0100;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("b2b_aok%0d", i), addr_ok, (i % 3 == 0));
      chk($sformatf("b2b_dok%0d", i), data_ok, (i % 3 == 2));
      chk($sformatf("b2b_busy%0d", i), busy, (i % 3 != 0));
      if (i % 3 == 2) chk($sformatf("b2b_rdata%0d", i), rdata, 32'h1234_BEEF);
      @(negedge clk);
    end
    req = 1'b0;

    // Reset one cycle after a write handshake: no response, write stays committed.
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h0000_0400; wdata = 32'hCAFE_F00D;
    chk("mid_aok", addr_ok, 1);
    @(negedge clk);
    req = 1'b0;
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_aok", addr_ok, 0);
    chk("mid_rst_rdata", rdata, 32'h0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (data_ok) seen = 1'b1;
    end
    rst = 1'b0;
    #1;
    chk("mid_rel_aok", addr_ok, 1);
    repeat (3) begin
      @(negedge clk);
      if (data_ok) seen = 1'b1;
    end
    chk("mid_no_dok", seen, 0);

    do_txn("post_rst_wr", 1'b0, 2'd2, 32'h0000_0400, 32'h0, 32'hCAFE_F00D);
    do_txn("post_rst_keep", 1'b0, 2'd2, 32'h0000_0100, 32'h0, 32'h1234_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
